// File: rtl/nbit_scan_mux_pkg.sv
// nbit_scan_mux_pkg: shared state encodings and width helpers for the scan mux
package nbit_scan_mux_pkg;

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  function automatic int num_ch(input int select_width);
    return 1 << select_width;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single-cycle dwell still needs a one-bit counter to hold the value 0
  function automatic int dwell_w(input int dwell);
    return (clog2(dwell) > 1) ? clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/nbit_scan_mux_if.sv
// nbit_scan_mux_if: channel bus, select controls and registered results of the scan mux
interface nbit_scan_mux_if #(
  parameter int SELECT_WIDTH = 4,
  parameter int DATA_WIDTH   = 8
);
  import nbit_scan_mux_pkg::*;
  localparam int NUM_CH = num_ch(SELECT_WIDTH);
  logic [NUM_CH*DATA_WIDTH-1:0] MuxIn;
  logic [SELECT_WIDTH-1:0]      MuxSel;
  logic                         SelLoad;
  logic                         ScanEn;
  logic [DATA_WIDTH-1:0]        MuxOut;
  logic [SELECT_WIDTH-1:0]      CurSel;
  logic                         OutValid;
  logic                         Wrap;
  modport master (
    output MuxIn, MuxSel, SelLoad, ScanEn,
    input  MuxOut, CurSel, OutValid, Wrap
  );
  modport slave (
    input  MuxIn, MuxSel, SelLoad, ScanEn,
    output MuxOut, CurSel, OutValid, Wrap
  );
endinterface

// File: rtl/nbit_scan_mux_wide_mux.sv
// nbit_wide_mux: combinational multi-bit channel selector over a flattened channel bus
module nbit_wide_mux #(
  parameter int SELECT_WIDTH = 4,
  parameter int DATA_WIDTH   = 8
) (
  input  logic [(2**SELECT_WIDTH)*DATA_WIDTH-1:0] mux_in,
  input  logic [SELECT_WIDTH-1:0]                 sel,
  output logic [DATA_WIDTH-1:0]                   y
);
  assign y = mux_in[sel*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: rtl/nbit_scan_mux.sv
// nbit_scan_mux: registered channel mux with direct select load and dwell-paced scanning
module nbit_scan_mux
  import nbit_scan_mux_pkg::*;
#(
  parameter int SELECT_WIDTH = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DWELL        = 4
) (
  input logic             Clk,
  input logic             Reset_n,
  nbit_scan_mux_if.slave  bus
);
  localparam int NUM_CH = num_ch(SELECT_WIDTH);
  localparam int DCW    = dwell_w(DWELL);

  state_e                  state_q, state_d;
  logic [DCW-1:0]          dwell_q, dwell_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    wrap_q, wrap_d;
  logic                    scan_act, adv;

  // The mux looks at the next select so MuxOut and CurSel always move together
  nbit_wide_mux #(
    .SELECT_WIDTH(SELECT_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_mux (
    .mux_in(bus.MuxIn),
    .sel   (sel_d),
    .y     (out_d)
  );

  // Next state: load beats advance; dwell only runs while already scanning with ScanEn held
  always_comb begin
    scan_act = (state_q == ST_SCAN) && bus.ScanEn;
    adv      = !bus.SelLoad && scan_act && (dwell_q == DCW'(DWELL - 1));
    state_d  = bus.ScanEn ? ST_SCAN : ST_DIRECT;
    sel_d    = bus.SelLoad ? bus.MuxSel : adv ? sel_q + SELECT_WIDTH'(1) : sel_q;
    dwell_d  = (bus.SelLoad || adv || !scan_act) ? '0 : dwell_q + DCW'(1);
    valid_d  = bus.SelLoad || adv;
    wrap_d   = adv && (sel_q == SELECT_WIDTH'(NUM_CH - 1));
  end

  // State, dwell counter and output registers with asynchronous clear
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_DIRECT;
      dwell_q <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.MuxOut   = out_q;
  assign bus.CurSel   = sel_q;
  assign bus.OutValid = valid_q;
  assign bus.Wrap     = wrap_q;
endmodule

// File: doc/nbit_scan_mux.md
Name: nbit_scan_mux

Overview:
Parametrised, registered successor to the single-bit nbit_mux. Selects one of 2**SELECT_WIDTH channels, each DATA_WIDTH bits wide, and registers the result. Two modes:
- DIRECT: the select is loaded on command.
- SCAN: an internal channel counter dwells DWELL cycles on each channel, then advances with wrap-around.

Used in the multicycle processor datapath for multi-bit operand selection and debug/observation scanning of register banks.

Parameters:
SELECT_WIDTH, 4, select bits; NUM_CH = 2**SELECT_WIDTH channels
DATA_WIDTH, 8, bits per channel
DWELL, 4, cycles spent on each channel in SCAN mode; legal range >= 1

Ports:
Clk  input  1  single clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
MuxIn  input  NUM_CH*DATA_WIDTH  flattened channels; channel i = MuxIn[i*DATA_WIDTH +: DATA_WIDTH]
MuxSel  input  SELECT_WIDTH  channel to load when SelLoad=1
SelLoad  input  1  load MuxSel into CurSel at this edge
ScanEn  input  1  level; 1 = SCAN mode, 0 = DIRECT mode
MuxOut  output  DATA_WIDTH  registered selected channel
CurSel  output  SELECT_WIDTH  currently selected channel (register)
OutValid  output  1  1-cycle pulse: MuxOut shows a newly selected channel
Wrap  output  1  1-cycle pulse: scan advanced from NUM_CH-1 to 0

Behaviour:
- Reset (Reset_n=0, asynchronous, no clock needed):
  - MuxOut=0, CurSel=0, OutValid=0, Wrap=0.
  - Dwell counter=0; state=DIRECT.
  - Outputs stay at these values until the first rising edge with Reset_n=1.
- State machine, two states:
  - DIRECT -> SCAN at an edge with ScanEn=1.
  - SCAN -> DIRECT at an edge with ScanEn=0.
  - Entering SCAN clears the dwell counter; CurSel holds.
- Dwell counter:
  - Width max(1, clog2(DWELL)).
  - Counts 0..DWELL-1 only while in SCAN.
  - Terminal when count == DWELL-1.
- Next-select priority, evaluated at each edge:
  1. SelLoad=1 (either mode): CurSel <= MuxSel; dwell counter <= 0. Wrap=0 even if MuxSel=0.
  2. Else if state==SCAN, ScanEn=1 and dwell terminal: CurSel <= CurSel+1 mod NUM_CH; dwell <= 0; Wrap <= 1 iff old CurSel == NUM_CH-1.
  3. Else: CurSel holds. Dwell increments if in SCAN with ScanEn=1; otherwise dwell is cleared.
- Exit priority: ScanEn=0 at a terminal-dwell edge gives no increment; the state returns to DIRECT and CurSel holds.
- Data path:
  - MuxOut <= channel[next CurSel] every edge, so MuxOut and CurSel always update together.
  - Latency is 1 cycle from a MuxIn change or a select change to MuxOut.
  - No combinational path from inputs to outputs.
- OutValid <= 1 at any edge where case 1 or case 2 fired (including a reload of the same value); otherwise 0.
- Wrap and OutValid are single-cycle pulses; they are never held.
- DWELL=1: in SCAN, CurSel advances every cycle; Wrap pulses every NUM_CH cycles.
- SelLoad while in SCAN: scanning resumes from the loaded channel with a full DWELL period before the next advance.
- Reset asserted mid-scan: immediate return to reset values. After release, the block restarts in DIRECT even if ScanEn=1 is held; it enters SCAN at the first edge.
- MuxSel out of range: impossible, since width is exact.

Decomposition:
- Shared package/include nbit_mux_defs:
  - NUM_CH derivation.
  - State encodings ST_DIRECT=1'b0, ST_SCAN=1'b1.
  - clog2 helper for the dwell counter width.
- Sub-module nbit_wide_mux (combinational, parameters SELECT_WIDTH and DATA_WIDTH): multi-bit generalisation of nbit_mux.
  - Instantiated once, driven by the next-CurSel value.
  - Its output feeds the MuxOut register.
- FSM, dwell counter and output registers live in nbit_scan_mux.

Test Plan (SELECT_WIDTH=4, DATA_WIDTH=8, DWELL=4, channel i preset to {4'hA, i}):
1. Reset: drive Reset_n=0 between clock edges -> MuxOut=8'h00, CurSel=0, OutValid=0, Wrap=0 immediately. Release Reset_n, idle -> MuxOut=8'hA0, OutValid=0.
2. Direct load: SelLoad=1, MuxSel=4'h5 for one cycle -> next edge CurSel=5, MuxOut=8'hA5, OutValid=1 for exactly one cycle. Then set channel 5 to 8'h3C -> MuxOut=8'h3C one edge later, OutValid=0.
3. Scan wrap: load 4'hE, then hold ScanEn=1:
   - SCAN is entered at the first edge; CurSel stays E for the following 4 edges.
   - CurSel then advances to F with MuxOut=8'hAF and OutValid=1.
   - 4 edges later CurSel=0, MuxOut=8'hA0, OutValid=1 and Wrap=1 in the same cycle.
4. Load during scan: in SCAN with dwell=2 on channel 7, SelLoad=1 with MuxSel=4'h3 -> CurSel=3, OutValid=1, Wrap=0. CurSel becomes 4 exactly 4 edges later.
5. Exit at terminal: drop ScanEn at the edge where dwell=3 on channel 9 -> CurSel stays 9, OutValid=0, state DIRECT; no further advance over 20 cycles.
6. DWELL=1 instance, ScanEn=1 from CurSel=0 -> CurSel increments every cycle; OutValid high continuously; Wrap high one cycle in every 16, coincident with CurSel=0.
